// File: rtl/progmem_arbiter.sv
// progmem_arbiter: round-robin sharing of one synchronous-read program memory among cores
`ifndef INST_ADDR_W
`define INST_ADDR_W 12
`endif
`ifndef INST_W
`define INST_W 32
`endif
module progmem_arbiter #(
   parameter int N_CORES = 4,
   parameter int ADDR_W  = `INST_ADDR_W,
   parameter int DATA_W  = `INST_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_CORES-1:0]        cfg_mask,
   input  logic [N_CORES-1:0]        req,
   input  logic [N_CORES*ADDR_W-1:0] req_addr,
   output logic [N_CORES-1:0]        gnt,
   output logic                      mem_en,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic [N_CORES-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data
);
   localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [N_CORES-1:0] rsp_q;
   // Walk the cores starting at ptr with wrap; first eligible one wins, nothing granted in reset
   always_comb begin
      logic [PW:0]   sum;
      logic [PW-1:0] idx;
      logic          found;
      gnt   = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < N_CORES; k++) begin
         sum = {1'b0, ptr_q} + (PW+1)'(k);
         idx = (sum >= (PW+1)'(N_CORES)) ? PW'(sum - (PW+1)'(N_CORES)) : sum[PW-1:0];
         if (!rst && !found && req[idx] && cfg_mask[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            ptr_d    = (idx == PW'(N_CORES-1)) ? '0 : idx + 1'b1;
         end
      end
   end
   // Route the granted core's address to the memory; zero when idle
   always_comb begin
      mem_addr = '0;
      for (int i = 0; i < N_CORES; i++)
         mem_addr = mem_addr | (gnt[i] ? req_addr[i*ADDR_W +: ADDR_W] : '0);
   end
   // Advance priority past the winner and remember who gets next cycle's read data
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         rsp_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         rsp_q <= gnt;
      end
   end
   assign mem_en    = |gnt;
   assign rsp_valid = rsp_q;
   assign rsp_data  = mem_rdata;
endmodule

// File: tb/tb_progmem_arbiter.sv
// tb_progmem_arbiter: scoreboard bench for progmem_arbiter against a priority-distance model
module tb_progmem_arbiter;
   localparam int N = 4, AW = 8, DW = 16;
   logic clk = 1'b0, rst = 1'b1;
   logic [N-1:0] cfg_mask = '1, req = '0, gnt, rsp_valid;
   logic [N*AW-1:0] req_addr = '0;
   logic mem_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata, rsp_data;
   logic [DW-1:0] mem [0:(1<<AW)-1];
   typedef struct {
      logic [N-1:0]  gnt;
      logic [AW-1:0] addr;
      logic [N-1:0]  rv;
      logic [DW-1:0] data;
   } exp_t;
   exp_t sb[$];
   exp_t e;
   int n_chk = 0, n_fail = 0;
   int m_ptr = 0;
   logic [N-1:0] m_rsp = '0;
   logic [AW-1:0] m_addr = '0;
   logic [AW-1:0] a [N];

   progmem_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .cfg_mask(cfg_mask), .req(req), .req_addr(req_addr),
      .gnt(gnt), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: drive inputs, predict this cycle's outputs, advance the model
   task automatic step(input logic r, input logic [N-1:0] m, input logic [N-1:0] q, output int g);
      exp_t x;
      int best_d;
      @(posedge clk);
      #1;
      rst = r;
      cfg_mask = m;
      req = q;
      for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = a[i];
      x.rv = m_rsp;
      x.data = mem[m_addr];
      x.gnt = '0;
      x.addr = '0;
      g = -1;
      best_d = N;
      if (!r)
         for (int i = 0; i < N; i++)
            if (q[i] && m[i] && ((i - m_ptr + N) % N) < best_d) begin
               best_d = (i - m_ptr + N) % N;
               g = i;
            end
      m_rsp = '0;
      if (g >= 0) begin
         x.gnt[g] = 1'b1;
         x.addr = a[g];
         m_ptr = (g + 1) % N;
         m_rsp[g] = 1'b1;
         m_addr = a[g];
      end else if (r) m_ptr = 0;
      sb.push_back(x);
   endtask

   // Monitor: compare every presented cycle against the queued expectation
   initial forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("gnt", 32'(gnt), 32'(e.gnt));
         check("mem_en", 32'(mem_en), 32'(|e.gnt));
         check("mem_addr", 32'(mem_addr), 32'(e.addr));
         check("rsp_valid", 32'(rsp_valid), 32'(e.rv));
         if (e.rv != '0) check("rsp_data", 32'(rsp_data), 32'(e.data));
      end
   end

   initial begin
      int g;
      logic r;
      logic [N-1:0] m, pend;
      for (int i = 0; i < (1<<AW); i++) mem[i] = DW'($urandom);
      for (int i = 0; i < N; i++) a[i] = '0;
      // lone requester on core 2, then all request to expose ptr=3
      step(1'b1, '1, '1, g);
      a[2] = 8'd5;
      mem[5] = 16'h00A5;
      step(1'b0, '1, 4'b0100, g);
      step(1'b0, '1, 4'b0000, g);
      for (int i = 0; i < N; i++) a[i] = AW'(i);
      for (int i = 0; i < N; i++) mem[i] = DW'(16'h10 + i);
      step(1'b0, '1, 4'b1111, g);
      // all four continuously from reset release
      step(1'b1, '1, '0, g);
      repeat (9) step(1'b0, '1, 4'b1111, g);
      // alternate cores 1 and 3 starting with ptr=2
      step(1'b1, '1, '0, g);
      a[1] = 8'd7;
      step(1'b0, '1, 4'b0010, g);
      repeat (5) step(1'b0, '1, 4'b1010, g);
      // masked-out core 2
      repeat (6) step(1'b0, 4'b1011, 4'b1111, g);
      // streaming core 0 with incrementing addresses
      step(1'b1, '1, '0, g);
      for (int k = 0; k < 10; k++) begin
         a[0] = AW'(20 + k);
         step(1'b0, '1, 4'b0001, g);
      end
      // reset right after granting core 1
      step(1'b0, '1, 4'b0010, g);
      step(1'b1, '1, 4'b1111, g);
      repeat (3) step(1'b0, '1, 4'b1111, g);
      // randomized cores holding requests until granted
      pend = '0;
      repeat (400) begin
         r = ($urandom_range(0, 39) == 0);
         m = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
         for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1'b1;
               a[i] = AW'($urandom);
            end
         step(r, m, pend, g);
         if (g >= 0) pend[g] = 1'b0;
      end
      step(1'b0, '1, '0, g);
      @(negedge clk);
      #1;
      check("drain", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
